multicycle_controller: RTL and testbench

- Control FSM that sequences a multicycle MIPS-subset datapath: lw, sw, R-type (add/sub/and/or/slt), beq, addi, j.
- Shares one unified instruction/data memory across fetch and data phases through a req/ready handshake with wait states.
- Drives all datapath enables and muxes. Decoding of funct to alucontrol lives in a sub-module.

---
 rtl/multicycle_pkg.sv | 62 ++++++
 rtl/multicycle_controller_alu_decoder.sv | 41 ++++
 rtl/multicycle_controller.sv | 189 ++++++++++++++++++
 tb/tb_multicycle_controller.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_pkg.sv
// Shared encodings for the multicycle MIPS-subset controller: state enum,
// opcode/funct constants, ALU control codes and datapath mux selects.
package multicycle_pkg;

   localparam int unsigned STATE_W  = 4;
   localparam int unsigned OPCODE_W = 6;
   localparam int unsigned FUNCT_W  = 6;
   localparam int unsigned ALUCTL_W = 4;
   localparam int unsigned SEL_W    = 2;

   typedef enum logic [STATE_W-1:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_ALUWB  = 4'd7,
      S_BRANCH = 4'd8,
      S_ADDIEX = 4'd9,
      S_ADDIWB = 4'd10,
      S_JUMP   = 4'd11,
      S_TRAP   = 4'd12
   } state_e;

   // Operation class handed to the ALU decoder
   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'd0,
      ALUOP_SUB   = 2'd1,
      ALUOP_FUNCT = 2'd2
   } aluop_e;

   localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
   localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
   localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
   localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
   localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;
   localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;

   localparam logic [FUNCT_W-1:0] FN_ADD = 6'b100000;
   localparam logic [FUNCT_W-1:0] FN_SUB = 6'b100010;
   localparam logic [FUNCT_W-1:0] FN_AND = 6'b100100;
   localparam logic [FUNCT_W-1:0] FN_OR  = 6'b100101;
   localparam logic [FUNCT_W-1:0] FN_SLT = 6'b101010;

   localparam logic [ALUCTL_W-1:0] ALU_AND = 4'b0000;
   localparam logic [ALUCTL_W-1:0] ALU_OR  = 4'b0001;
   localparam logic [ALUCTL_W-1:0] ALU_ADD = 4'b0010;
   localparam logic [ALUCTL_W-1:0] ALU_SUB = 4'b0110;
   localparam logic [ALUCTL_W-1:0] ALU_SLT = 4'b0111;

   localparam logic [SEL_W-1:0] SRCB_RT      = 2'b00;
   localparam logic [SEL_W-1:0] SRCB_FOUR    = 2'b01;
   localparam logic [SEL_W-1:0] SRCB_IMM     = 2'b10;
   localparam logic [SEL_W-1:0] SRCB_IMM_SH2 = 2'b11;

   localparam logic [SEL_W-1:0] PCSRC_ALU    = 2'b00;
   localparam logic [SEL_W-1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [SEL_W-1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// alu_decoder: combinational map of op class + funct to ALU control.
//   aluop_i       : add / sub / funct-driven
//   funct_i       : instr[5:0]
//   alucontrol_o  : ALU operation code
//   funct_valid_o : funct is one of the supported R-type operations
module alu_decoder
   import multicycle_pkg::*;
(
   input  aluop_e              aluop_i,
   input  logic [FUNCT_W-1:0]  funct_i,
   output logic [ALUCTL_W-1:0] alucontrol_o,
   output logic                funct_valid_o
);

   logic [ALUCTL_W-1:0] funct_alu;

   // funct decode, independent of op class so DECODE can test validity
   always_comb begin
      funct_alu     = ALU_ADD;
      funct_valid_o = 1'b1;
      case (funct_i)
         FN_ADD:  funct_alu = ALU_ADD;
         FN_SUB:  funct_alu = ALU_SUB;
         FN_AND:  funct_alu = ALU_AND;
         FN_OR:   funct_alu = ALU_OR;
         FN_SLT:  funct_alu = ALU_SLT;
         default: funct_valid_o = 1'b0;
      endcase
   end

   always_comb begin
      alucontrol_o = ALU_ADD;
      case (aluop_i)
         ALUOP_ADD:   alucontrol_o = ALU_ADD;
         ALUOP_SUB:   alucontrol_o = ALU_SUB;
         ALUOP_FUNCT: alucontrol_o = funct_alu;
         default:     alucontrol_o = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: control FSM for a multicycle MIPS-subset datapath
// sharing one memory for fetch and data through a req/ready handshake.
//   clk, reset (async, active low)
//   opcode, funct, zero, mem_ready : instruction fields, ALU flag, memory done
//   mem_req, memwrite, iord        : memory access control
//   irwrite, datawrite, pcen, pcsrc: register load enables / next-PC select
//   alusrca, alusrcb, alucontrol   : ALU operand selects and operation
//   regdst, memtoreg, regwrite     : register file writeback control
//   illegal, state                 : trap flag and debug state
module multicycle_controller
   import multicycle_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic [FUNCT_W-1:0]  funct,
   input  logic                zero,
   input  logic                mem_ready,
   output logic                mem_req,
   output logic                memwrite,
   output logic                iord,
   output logic                irwrite,
   output logic                datawrite,
   output logic                pcen,
   output logic [SEL_W-1:0]    pcsrc,
   output logic                alusrca,
   output logic [SEL_W-1:0]    alusrcb,
   output logic [ALUCTL_W-1:0] alucontrol,
   output logic                regdst,
   output logic                memtoreg,
   output logic                regwrite,
   output logic                illegal,
   output logic [STATE_W-1:0]  state
);

   state_e              state_q, state_d;
   aluop_e              aluop;
   logic                alu_used;
   logic [ALUCTL_W-1:0] dec_alucontrol;
   logic                funct_valid;
   logic                pcwrite, branch;

   alu_decoder u_alu_decoder (
      .aluop_i       (aluop),
      .funct_i       (funct),
      .alucontrol_o  (dec_alucontrol),
      .funct_valid_o (funct_valid)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= S_FETCH;
      else        state_q <= state_d;
   end

   // ALU operation class per state; alucontrol reads 0 where the ALU is idle
   always_comb begin
      aluop    = ALUOP_ADD;
      alu_used = 1'b0;
      case (state_q)
         S_FETCH, S_DECODE, S_MEMADR, S_ADDIEX: alu_used = 1'b1;
         S_EXEC: begin
            aluop    = ALUOP_FUNCT;
            alu_used = 1'b1;
         end
         S_BRANCH: begin
            aluop    = ALUOP_SUB;
            alu_used = 1'b1;
         end
         default: ;
      endcase
   end

   assign alucontrol = (reset && alu_used) ? dec_alucontrol : '0;

   // Next state and Moore outputs; handshake states gate loads with mem_ready
   always_comb begin
      state_d   = state_q;
      mem_req   = 1'b0;
      memwrite  = 1'b0;
      iord      = 1'b0;
      irwrite   = 1'b0;
      datawrite = 1'b0;
      pcwrite   = 1'b0;
      branch    = 1'b0;
      pcsrc     = PCSRC_ALU;
      alusrca   = 1'b0;
      alusrcb   = SRCB_RT;
      regdst    = 1'b0;
      memtoreg  = 1'b0;
      regwrite  = 1'b0;
      illegal   = 1'b0;
      state     = state_q;

      case (state_q)
         S_FETCH: begin
            mem_req = 1'b1;
            alusrcb = SRCB_FOUR;
            irwrite = mem_ready;
            pcwrite = mem_ready;
            if (mem_ready) state_d = S_DECODE;
         end
         S_DECODE: begin
            alusrcb = SRCB_IMM_SH2;
            case (opcode)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = funct_valid ? S_EXEC : S_TRAP;
               OP_BEQ:       state_d = S_BRANCH;
               OP_ADDI:      state_d = S_ADDIEX;
               OP_J:         state_d = S_JUMP;
               default:      state_d = S_TRAP;
            endcase
         end
         S_MEMADR: begin
            alusrca = 1'b1;
            alusrcb = SRCB_IMM;
            state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            mem_req   = 1'b1;
            iord      = 1'b1;
            datawrite = mem_ready;
            if (mem_ready) state_d = S_MEMWB;
         end
         S_MEMWB: begin
            regwrite = 1'b1;
            memtoreg = 1'b1;
            state_d  = S_FETCH;
         end
         S_MEMWR: begin
            mem_req  = 1'b1;
            memwrite = 1'b1;
            iord     = 1'b1;
            if (mem_ready) state_d = S_FETCH;
         end
         S_EXEC: begin
            alusrca = 1'b1;
            state_d = S_ALUWB;
         end
         S_ALUWB: begin
            regwrite = 1'b1;
            regdst   = 1'b1;
            state_d  = S_FETCH;
         end
         S_BRANCH: begin
            alusrca = 1'b1;
            pcsrc   = PCSRC_ALUOUT;
            branch  = 1'b1;
            state_d = S_FETCH;
         end
         S_ADDIEX: begin
            alusrca = 1'b1;
            alusrcb = SRCB_IMM;
            state_d = S_ADDIWB;
         end
         S_ADDIWB: begin
            regwrite = 1'b1;
            state_d  = S_FETCH;
         end
         S_JUMP: begin
            pcsrc   = PCSRC_JUMP;
            pcwrite = 1'b1;
            state_d = S_FETCH;
         end
         S_TRAP: illegal = 1'b1;
         default: state_d = S_TRAP;
      endcase

      pcen = pcwrite | (branch & zero);

      // Reset silences every output, including the pending fetch request
      if (!reset) begin
         mem_req   = 1'b0;
         memwrite  = 1'b0;
         iord      = 1'b0;
         irwrite   = 1'b0;
         datawrite = 1'b0;
         pcen      = 1'b0;
         pcsrc     = '0;
         alusrca   = 1'b0;
         alusrcb   = '0;
         regdst    = 1'b0;
         memtoreg  = 1'b0;
         regwrite  = 1'b0;
         illegal   = 1'b0;
         state     = '0;
      end
   end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: instruction-level reference
// model expands each instruction into its expected per-cycle control words.
module tb_multicycle_controller;
   import multicycle_pkg::*;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [5:0] opcode = '0;
   logic [5:0] funct = '0;
   logic       zero = 1'b0;
   logic       mem_ready = 1'b0;
   logic       mem_req, memwrite, iord, irwrite, datawrite, pcen;
   logic [1:0] pcsrc, alusrcb;
   logic       alusrca, regdst, memtoreg, regwrite, illegal;
   logic [3:0] alucontrol, state;

   multicycle_controller dut (
      .clk        (clk),
      .reset      (reset),
      .opcode     (opcode),
      .funct      (funct),
      .zero       (zero),
      .mem_ready  (mem_ready),
      .mem_req    (mem_req),
      .memwrite   (memwrite),
      .iord       (iord),
      .irwrite    (irwrite),
      .datawrite  (datawrite),
      .pcen       (pcen),
      .pcsrc      (pcsrc),
      .alusrca    (alusrca),
      .alusrcb    (alusrcb),
      .alucontrol (alucontrol),
      .regdst     (regdst),
      .memtoreg   (memtoreg),
      .regwrite   (regwrite),
      .illegal    (illegal),
      .state      (state)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       mem_req;
      logic       memwrite;
      logic       iord;
      logic       irwrite;
      logic       datawrite;
      logic       pcen;
      logic [1:0] pcsrc;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic [3:0] alucontrol;
      logic       regdst;
      logic       memtoreg;
      logic       regwrite;
      logic       illegal;
      logic [3:0] state;
   } ctl_t;

   ctl_t exp_q[$];
   ctl_t act, mon_e;
   int   n_tests = 0;
   int   n_fail = 0;
   int   cyc_no = 0;
   int   k, fw, dw;
   logic [5:0] fn_r;
   logic [5:0] legal_fn [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

   always_comb begin
      act.mem_req    = mem_req;
      act.memwrite   = memwrite;
      act.iord       = iord;
      act.irwrite    = irwrite;
      act.datawrite  = datawrite;
      act.pcen       = pcen;
      act.pcsrc      = pcsrc;
      act.alusrca    = alusrca;
      act.alusrcb    = alusrcb;
      act.alucontrol = alucontrol;
      act.regdst     = regdst;
      act.memtoreg   = memtoreg;
      act.regwrite   = regwrite;
      act.illegal    = illegal;
      act.state      = state;
   end

   // Monitor: compares DUT outputs with the next queued expectation
   always @(negedge clk) begin
      cyc_no++;
      if (exp_q.size() != 0) begin
         mon_e = exp_q.pop_front();
         n_tests++;
         if (act !== mon_e) begin
            n_fail++;
            $display("FAIL ctl cycle %0d: got %h expected %h (got state %0d expected state %0d)",
                     cyc_no, act, mon_e, act.state, mon_e.state);
         end
      end
   end

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic ctl_t blank(input state_e s);
      ctl_t c = '0;
      c.state = 4'(s);
      return c;
   endfunction

   function automatic logic [3:0] alu_of(input logic [5:0] fn);
      case (fn)
         6'b100000: return 4'b0010;
         6'b100010: return 4'b0110;
         6'b100100: return 4'b0000;
         6'b100101: return 4'b0001;
         default:   return 4'b0111;
      endcase
   endfunction

   // Per-phase control words as listed for each step of an instruction
   function automatic ctl_t x_fetch(input logic rdy);
      ctl_t c = blank(S_FETCH);
      c.mem_req = 1'b1; c.alusrcb = 2'b01; c.alucontrol = 4'b0010;
      c.irwrite = rdy;  c.pcen = rdy;
      return c;
   endfunction

   function automatic ctl_t x_alu(input state_e s, input logic a, input logic [1:0] b,
                                  input logic [3:0] ac);
      ctl_t c = blank(s);
      c.alusrca = a; c.alusrcb = b; c.alucontrol = ac;
      return c;
   endfunction

   function automatic ctl_t x_mem(input state_e s, input logic wr, input logic dwr);
      ctl_t c = blank(s);
      c.mem_req = 1'b1; c.iord = 1'b1; c.memwrite = wr; c.datawrite = dwr;
      return c;
   endfunction

   function automatic ctl_t x_wb(input state_e s, input logic rd, input logic m2r);
      ctl_t c = blank(s);
      c.regwrite = 1'b1; c.regdst = rd; c.memtoreg = m2r;
      return c;
   endfunction

   function automatic ctl_t x_branch(input logic z);
      ctl_t c = x_alu(S_BRANCH, 1'b1, 2'b00, 4'b0110);
      c.pcsrc = 2'b01; c.pcen = z;
      return c;
   endfunction

   function automatic ctl_t x_jump();
      ctl_t c = blank(S_JUMP);
      c.pcsrc = 2'b10; c.pcen = 1'b1;
      return c;
   endfunction

   function automatic ctl_t x_trap();
      ctl_t c = blank(S_TRAP);
      c.illegal = 1'b1;
      return c;
   endfunction

   // One clock cycle: drive inputs, queue the expectation, advance
   task automatic cyc(input ctl_t e, input logic rdy, input logic z, input logic rst);
      reset = rst; mem_ready = rdy; zero = z;
      exp_q.push_back(e);
      @(posedge clk); #1;
   endtask

   // kind: 0 lw, 1 sw, 2 R-type, 3 beq, 4 addi, 5 j, 6 bad opcode, 7 bad funct
   task automatic run_instr(input int kd, input logic [5:0] fn, input int fwait,
                            input int dwait, input logic z);
      logic [5:0] op;
      case (kd)
         0:       op = 6'b100011;
         1:       op = 6'b101011;
         2, 7:    op = 6'b000000;
         3:       op = 6'b000100;
         4:       op = 6'b001000;
         5:       op = 6'b000010;
         default: begin
            do op = 6'($urandom);
            while (op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010});
         end
      endcase
      opcode = op; funct = fn;
      repeat (fwait) cyc(x_fetch(1'b0), 1'b0, rb(), 1'b1);
      cyc(x_fetch(1'b1), 1'b1, rb(), 1'b1);
      cyc(x_alu(S_DECODE, 1'b0, 2'b11, 4'b0010), rb(), rb(), 1'b1);
      case (kd)
         0: begin
            cyc(x_alu(S_MEMADR, 1'b1, 2'b10, 4'b0010), rb(), rb(), 1'b1);
            repeat (dwait) cyc(x_mem(S_MEMRD, 1'b0, 1'b0), 1'b0, rb(), 1'b1);
            cyc(x_mem(S_MEMRD, 1'b0, 1'b1), 1'b1, rb(), 1'b1);
            cyc(x_wb(S_MEMWB, 1'b0, 1'b1), rb(), rb(), 1'b1);
         end
         1: begin
            cyc(x_alu(S_MEMADR, 1'b1, 2'b10, 4'b0010), rb(), rb(), 1'b1);
            repeat (dwait) cyc(x_mem(S_MEMWR, 1'b1, 1'b0), 1'b0, rb(), 1'b1);
            cyc(x_mem(S_MEMWR, 1'b1, 1'b0), 1'b1, rb(), 1'b1);
         end
         2: begin
            cyc(x_alu(S_EXEC, 1'b1, 2'b00, alu_of(fn)), rb(), rb(), 1'b1);
            cyc(x_wb(S_ALUWB, 1'b1, 1'b0), rb(), rb(), 1'b1);
         end
         3: cyc(x_branch(z), rb(), z, 1'b1);
         4: begin
            cyc(x_alu(S_ADDIEX, 1'b1, 2'b10, 4'b0010), rb(), rb(), 1'b1);
            cyc(x_wb(S_ADDIWB, 1'b0, 1'b0), rb(), rb(), 1'b1);
         end
         5: cyc(x_jump(), rb(), rb(), 1'b1);
         default: begin
            repeat (10) cyc(x_trap(), rb(), rb(), 1'b1);
            repeat (2) cyc(blank(S_FETCH), rb(), rb(), 1'b0);
         end
      endcase
   endtask

   initial begin
      @(posedge clk); #1;
      repeat (2) cyc(blank(S_FETCH), 1'b1, 1'b0, 1'b0);

      run_instr(2, 6'b100000, 0, 0, 1'b0);
      run_instr(0, 6'b000000, 0, 2, 1'b0);
      run_instr(3, 6'b000000, 0, 0, 1'b1);
      run_instr(3, 6'b000000, 0, 0, 1'b0);
      run_instr(1, 6'b000000, 0, 1, 1'b0);
      run_instr(6, 6'b000000, 0, 0, 1'b0);
      run_instr(7, 6'b000001, 0, 0, 1'b0);
      run_instr(4, 6'b000000, 1, 0, 1'b0);
      run_instr(5, 6'b000000, 2, 0, 1'b0);

      // Reset while MEMRD waits: outputs drop at once, no data load
      opcode = 6'b100011; funct = '0;
      cyc(x_fetch(1'b1), 1'b1, 1'b0, 1'b1);
      cyc(x_alu(S_DECODE, 1'b0, 2'b11, 4'b0010), 1'b0, 1'b0, 1'b1);
      cyc(x_alu(S_MEMADR, 1'b1, 2'b10, 4'b0010), 1'b0, 1'b0, 1'b1);
      cyc(x_mem(S_MEMRD, 1'b0, 1'b0), 1'b0, 1'b0, 1'b1);
      repeat (2) cyc(blank(S_FETCH), 1'b1, 1'b1, 1'b0);

      for (int i = 0; i < 300; i++) begin
         k  = $urandom_range(0, 7);
         fw = $urandom_range(0, 2);
         dw = $urandom_range(0, 2);
         fn_r = legal_fn[$urandom_range(0, 4)];
         if (k == 7) begin
            do fn_r = 6'($urandom);
            while (fn_r inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010});
         end else if (k != 2) begin
            fn_r = 6'($urandom);
         end
         run_instr(k, fn_r, fw, dw, rb());
      end

      @(negedge clk); #1;
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
